// File: rtl/keypoint_reader_pkg.sv
// Shared constants, packing offsets and types for the keypoint SRAM writer/reader pair.
// Both ends import this so the {row, col} packing of a keypoint word stays in one place.
package keypoint_reader_pkg;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 21;
  localparam int ROW_W   = 9;
  localparam int COL_W   = 10;
  localparam int MAX_KP  = 2000;
  localparam int ROW_LSB = 10;
  localparam int COL_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD1   = 2'd1,
    RD2   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic             last;
    logic             bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } kp_entry_t;

  function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] n);
    return (n > ADDR_W'(MAX_KP)) ? ADDR_W'(MAX_KP) : n;
  endfunction

endpackage

// File: rtl/kp_fifo2.sv
// Two-entry synchronous FIFO for returned keypoints; push and pop may coincide at any
// occupancy, including full, so a full FIFO still sustains one entry per cycle.
module kp_fifo2
  import keypoint_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  kp_entry_t  push_data,
  input  logic       pop,
  output kp_entry_t  head,
  output logic       full,
  output logic       empty,
  output logic [1:0] occupancy
);

  kp_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // NOTE: storage has no reset; validity comes only from the reset pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head      = mem[rd_ptr];
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign occupancy = count;

endmodule

// File: rtl/keypoint_reader.sv
// Drains keypoint bank 1 then bank 2 after detection and streams {row, col, bank, last}
// over valid/ready, using a credit count so at most two keypoints are ever committed.
module keypoint_reader
  import keypoint_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] kp1_count,
  input  logic [ADDR_W-1:0] kp2_count,
  output logic              keypoint_1_re,
  output logic [ADDR_W-1:0] keypoint_1_addr,
  input  logic [DATA_W-1:0] keypoint_1_dout,
  output logic              keypoint_2_re,
  output logic [ADDR_W-1:0] keypoint_2_addr,
  input  logic [DATA_W-1:0] keypoint_2_dout,
  output logic              kp_valid,
  input  logic              kp_ready,
  output logic [ROW_W-1:0]  kp_row,
  output logic [COL_W-1:0]  kp_col,
  output logic              kp_bank,
  output logic              kp_last,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] cnt1, cnt2, addr1, addr2;
  logic [ADDR_W-1:0] clamp1, clamp2;
  logic              inflight, inflight_bank, inflight_last, done_r;
  logic              re1, re2, re_last, pop, credit_ok, drain_ok;
  logic [2:0]        pending;
  logic [DATA_W-1:0] ret_word;
  logic [DATA_W-1:ROW_LSB+ROW_W] unused_reserved;
  kp_entry_t         ret_entry, fifo_head, out_entry;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]        fifo_occ;

  assign clamp1 = clamp_count(kp1_count);
  assign clamp2 = clamp_count(kp2_count);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ret_word       = inflight_bank ? keypoint_2_dout : keypoint_1_dout;
    ret_entry      = '0;
    ret_entry.row  = ret_word[ROW_LSB +: ROW_W];
    ret_entry.col  = ret_word[COL_LSB +: COL_W];
    ret_entry.bank = inflight_bank;
    ret_entry.last = inflight_last;
  end
  assign unused_reserved = ret_word[DATA_W-1:ROW_LSB+ROW_W];

  // Returning data bypasses an empty FIFO so kp_valid rises in the cycle the word lands.
  assign kp_valid  = !fifo_empty || inflight;
  assign pop       = kp_valid && kp_ready;
  assign out_entry = fifo_empty ? ret_entry : fifo_head;
  assign fifo_push = inflight && !(fifo_empty && pop) && (!fifo_full || pop);
  assign fifo_pop  = pop && !fifo_empty;

  // Entries still owed downstream after this edge; a new read is allowed only below two.
  assign pending   = 3'(fifo_occ) + 3'(inflight) - 3'(pop);
  assign credit_ok = (pending < 3'd2);
  assign drain_ok  = (pending == 3'd0);

  assign re1     = (state == RD1) && (addr1 < cnt1) && credit_ok;
  assign re2     = (state == RD2) && (addr2 < cnt2) && credit_ok;
  assign re_last = (re1 && (addr1 == cnt1 - ADDR_W'(1)) && (cnt2 == '0)) ||
                   (re2 && (addr2 == cnt2 - ADDR_W'(1)));

  kp_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ret_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt1          <= '0;
      cnt2          <= '0;
      addr1         <= '0;
      addr2         <= '0;
      inflight      <= 1'b0;
      inflight_bank <= 1'b0;
      inflight_last <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      inflight      <= re1 | re2;
      inflight_bank <= re2;
      inflight_last <= re_last;
      done_r        <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt1 <= clamp1;
          cnt2 <= clamp2;
          if (clamp1 != '0)      state <= RD1;
          else if (clamp2 != '0) state <= RD2;
          else                   state <= DRAIN;
        end
        RD1: if (re1) begin
          addr1 <= addr1 + ADDR_W'(1);
          if (addr1 == cnt1 - ADDR_W'(1)) state <= (cnt2 != '0) ? RD2 : DRAIN;
        end
        RD2: if (re2) begin
          addr2 <= addr2 + ADDR_W'(1);
          if (addr2 == cnt2 - ADDR_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // done is flagged once nothing is owed, then held for the exit cycle back to IDLE.
          if (done_r) begin
            state <= IDLE;
            addr1 <= '0;
            addr2 <= '0;
          end else if (drain_ok) begin
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign keypoint_1_re   = re1;
  assign keypoint_2_re   = re2;
  assign keypoint_1_addr = addr1;
  assign keypoint_2_addr = addr2;
  assign kp_row          = kp_valid ? out_entry.row  : '0;
  assign kp_col          = kp_valid ? out_entry.col  : '0;
  assign kp_bank         = kp_valid ? out_entry.bank : 1'b0;
  assign kp_last         = kp_valid ? out_entry.last : 1'b0;
  assign busy            = (state != IDLE);
  assign done            = done_r;

endmodule

// File: tb/tb_keypoint_reader.sv
// Self-checking bench for keypoint_reader: SRAM models, a queue-based reference of the
// expected keypoint stream, and directed plus randomized read-outs.
module tb_keypoint_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] kp1_count, kp2_count;
  logic        keypoint_1_re, keypoint_2_re;
  logic [10:0] keypoint_1_addr, keypoint_2_addr;
  logic [20:0] keypoint_1_dout, keypoint_2_dout;
  logic        kp_valid, kp_ready;
  logic [8:0]  kp_row;
  logic [9:0]  kp_col;
  logic        kp_bank, kp_last, busy, done;

  keypoint_reader dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .kp1_count       (kp1_count),
    .kp2_count       (kp2_count),
    .keypoint_1_re   (keypoint_1_re),
    .keypoint_1_addr (keypoint_1_addr),
    .keypoint_1_dout (keypoint_1_dout),
    .keypoint_2_re   (keypoint_2_re),
    .keypoint_2_addr (keypoint_2_addr),
    .keypoint_2_dout (keypoint_2_dout),
    .kp_valid        (kp_valid),
    .kp_ready        (kp_ready),
    .kp_row          (kp_row),
    .kp_col          (kp_col),
    .kp_bank         (kp_bank),
    .kp_last         (kp_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM models: data appears the cycle after re.
  logic [20:0] mem1 [2048];
  logic [20:0] mem2 [2048];
  always @(posedge clk) begin
    if (keypoint_1_re) keypoint_1_dout <= mem1[keypoint_1_addr];
    if (keypoint_2_re) keypoint_2_dout <= mem2[keypoint_2_addr];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the full expected stream is built when a run starts.
  typedef struct {
    logic       bank;
    logic       last;
    logic [8:0] row;
    logic [9:0] col;
  } exp_t;

  exp_t exp_q[$];
  bit   active = 1'b0;
  int   start_cyc = 0, n1 = 0, n2 = 0, a1 = 0, a2 = 0;
  int   issued = 0, hs = 0, last_hs = 0, done_seen = 0, hs_total = 0, last_addr1 = 0;

  function automatic int clamp(input int c);
    return (c > 2000) ? 2000 : c;
  endfunction

  task automatic build_stream(input int c1, input int c2);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < c1; i++) begin
      e.bank = 1'b0; e.row = mem1[i][18:10]; e.col = mem1[i][9:0];
      e.last = (i == c1 - 1) && (c2 == 0);
      exp_q.push_back(e);
    end
    for (int j = 0; j < c2; j++) begin
      e.bank = 1'b1; e.row = mem2[j][18:10]; e.col = mem2[j][9:0];
      e.last = (j == c2 - 1);
      exp_q.push_back(e);
    end
  endtask

  // Compare process: every cycle, on the falling edge, against the model.
  always @(negedge clk) begin : compare
    int   outstanding;
    logic popn;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      active = 1'b0;
      issued = 0; hs = 0; a1 = 0; a2 = 0;
    end else begin
      popn        = kp_valid && kp_ready;
      outstanding = issued - hs;
      check("busy", 32'(busy), 32'(active && (cyc > start_cyc)));
      check("re_onehot", 32'(keypoint_1_re && keypoint_2_re), 0);
      if (keypoint_1_re) begin
        check("re1_addr", 32'(keypoint_1_addr), a1);
        check("re1_allowed", 32'(active && (a1 < n1)), 1);
        check("re1_credit", 32'((outstanding - int'(popn)) < 2), 1);
        last_addr1 = int'(keypoint_1_addr);
        a1++; issued++;
      end
      if (keypoint_2_re) begin
        check("re2_addr", 32'(keypoint_2_addr), a2);
        check("re2_allowed", 32'(active && (a1 == n1) && (a2 < n2)), 1);
        check("re2_credit", 32'((outstanding - int'(popn)) < 2), 1);
        a2++; issued++;
      end
      if (exp_q.size() == 0) begin
        check("kp_valid_when_nothing_owed", 32'(kp_valid), 0);
      end else if (kp_valid) begin
        e = exp_q[0];
        check("kp_fields", 32'({kp_bank, kp_last, kp_row, kp_col}),
              32'({e.bank, e.last, e.row, e.col}));
        if (kp_ready) begin
          void'(exp_q.pop_front());
          hs++;
          last_hs = cyc;
        end
      end
      if (start && !active) begin
        n1 = clamp(int'(kp1_count));
        n2 = clamp(int'(kp2_count));
        build_stream(n1, n2);
        active = 1'b1; start_cyc = cyc;
        a1 = 0; a2 = 0; issued = 0; hs = 0;
      end
      if (done) begin
        check("done_while_active", 32'(active), 1);
        check("done_stream_empty", 32'(exp_q.size()), 0);
        check("done_cycle", cyc, (hs > 0) ? last_hs + 1 : start_cyc + 2);
        done_seen++;
        hs_total = hs;
        active = 1'b0;
      end
    end
  end

  initial begin
    kp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       kp_ready = 1'b1;
        1:       kp_ready = ~kp_ready;
        default: kp_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  task automatic fill_random();
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = 21'($urandom);
      mem2[i] = 21'($urandom);
    end
  endtask

  // start is held through exactly one sampling edge; returns in cycle 1 after posedge.
  task automatic do_start(input int c1, input int c2);
    @(posedge clk); #1;
    kp1_count = 11'(c1);
    kp2_count = 11'(c2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_seen;
    for (int k = 0; k < budget && done_seen == d0; k++) @(posedge clk);
    check(name, 32'(done_seen != d0), 1);
    repeat (2) @(posedge clk);
  endtask

  int t1_row [5] = '{1, 2, 3, 4, 5};
  int t1_col [5] = '{5, 6, 7, 8, 9};
  int t1_bank[5] = '{0, 0, 0, 1, 1};
  int t1_last[5] = '{0, 0, 0, 0, 1};

  initial begin
    int d0;
    int c1, c2;
    rst = 1'b1; start = 1'b0; kp1_count = '0; kp2_count = '0;
    fill_random();
    repeat (3) @(posedge clk); #1;
    check("reset_kp_valid", 32'(kp_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_re", 32'({keypoint_1_re, keypoint_2_re}), 0);
    rst = 1'b0;

    // Directed stream with literal expectations.
    for (int i = 0; i < 3; i++) mem1[i] = {2'b11, 9'(i + 1), 10'(i + 5)};
    for (int i = 0; i < 2; i++) mem2[i] = {2'b11, 9'(i + 4), 10'(i + 8)};
    ready_mode = 0;
    d0 = done_seen;
    do_start(3, 2);
    @(negedge clk);
    check("t1_c1_re1", 32'(keypoint_1_re), 1);
    check("t1_c1_addr", 32'(keypoint_1_addr), 0);
    check("t1_c1_valid", 32'(kp_valid), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_valid", 32'(kp_valid), 1);
      check("t1_row", 32'(kp_row), t1_row[k]);
      check("t1_col", 32'(kp_col), t1_col[k]);
      check("t1_bank", 32'(kp_bank), t1_bank[k]);
      check("t1_last", 32'(kp_last), t1_last[k]);
    end
    @(negedge clk);
    check("t1_done", 32'(done), 1);
    check("t1_done_valid", 32'(kp_valid), 0);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_done_count", done_seen - d0, 1);

    // Bank 1 only with a toggling consumer.
    fill_random();
    ready_mode = 1;
    do_start(4, 0);
    wait_done(100, "t2_done");
    check("t2_handshakes", hs_total, 4);

    // Both banks empty.
    ready_mode = 0;
    do_start(0, 0);
    @(negedge clk);
    check("t3_c1_busy", 32'(busy), 1);
    check("t3_c1_done", 32'(done), 0);
    check("t3_c1_re", 32'({keypoint_1_re, keypoint_2_re, kp_valid}), 0);
    @(negedge clk);
    check("t3_c2_busy", 32'(busy), 1);
    check("t3_c2_done", 32'(done), 1);
    @(negedge clk);
    check("t3_c3_busy", 32'(busy), 0);
    check("t3_c3_done", 32'(done), 0);

    // Clamped bank 1 count.
    fill_random();
    ready_mode = 2;
    do_start(2047, 5);
    wait_done(8000, "t4_done");
    check("t4_handshakes", hs_total, 2005);
    check("t4_last_addr1", last_addr1, 1999);

    // Reset mid-stream, then replay.
    ready_mode = 0;
    do_start(6, 3);
    for (int k = 0; k < 100 && hs < 3; k++) @(posedge clk);
    check("t5_reached_3", 32'(hs >= 3), 1);
    #1 rst = 1'b1;
    d0 = done_seen;
    #1;
    check("t5_rst_outputs", 32'({kp_valid, keypoint_1_re, keypoint_2_re, busy, done,
                                  kp_bank, kp_last, kp_row, kp_col}), 0);
    check("t5_rst_addrs", 32'({keypoint_1_addr, keypoint_2_addr}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("t5_no_done", done_seen - d0, 0);
    do_start(6, 3);
    wait_done(200, "t5_done");
    check("t5_handshakes", hs_total, 9);

    // start while busy is ignored.
    fill_random();
    ready_mode = 2;
    do_start(5, 2);
    repeat (2) @(posedge clk);
    #1 kp1_count = 11'd1; kp2_count = 11'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200, "t6_done");
    check("t6_handshakes", hs_total, 7);

    // Randomized small read-outs.
    for (int r = 0; r < 6; r++) begin
      fill_random();
      c1 = int'($urandom_range(0, 12));
      c2 = int'($urandom_range(0, 12));
      ready_mode = 2;
      do_start(c1, c2);
      wait_done(400, "rand_done");
      check("rand_handshakes", hs_total, c1 + c2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypoint_reader.md
Name: keypoint_reader

Overview:
- Read-side counterpart of the keypoint detect/filter stage.
- After detection completes, this block drains the two keypoint SRAMs (bank 1, then bank 2) and streams each packed keypoint {row, col} downstream over a valid/ready interface, tagged with its bank.
- It feeds the orientation/descriptor stages and pulses done when both banks are exhausted.

Parameters:
- ADDR_W, 11, keypoint SRAM address width (2K entries)
- DATA_W, 21, keypoint SRAM word width
- ROW_W, 9, row field width
- COL_W, 10, column field width
- MAX_KP, 2000, maximum keypoints per bank; larger counts are clamped to this

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; latches counts and begins the read-out
- kp1_count  in  ADDR_W  number of valid entries in bank 1
- kp2_count  in  ADDR_W  number of valid entries in bank 2
- keypoint_1_re  out  1  bank 1 read enable
- keypoint_1_addr  out  ADDR_W  bank 1 read address
- keypoint_1_dout  in  DATA_W  bank 1 read data, valid 1 cycle after re
- keypoint_2_re  out  1  bank 2 read enable
- keypoint_2_addr  out  ADDR_W  bank 2 read address
- keypoint_2_dout  in  DATA_W  bank 2 read data, valid 1 cycle after re
- kp_valid  out  1  output keypoint valid
- kp_ready  in  1  downstream accepts
- kp_row  out  ROW_W  row = dout[18:10]
- kp_col  out  COL_W  col = dout[9:0]
- kp_bank  out  1  0 = bank 1, 1 = bank 2
- kp_last  out  1  final keypoint of the whole read-out
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO empty; counters 0. Reset asserted mid-operation aborts immediately with no done pulse. Read data returning after reset is discarded.
- FSM states: IDLE, RD1, RD2, DRAIN.
  - IDLE + start: latch min(kpN_count, MAX_KP) for each bank. Go to RD1 if cnt1 > 0, else RD2 if cnt2 > 0, else DRAIN.
  - RD1 → RD2 (or DRAIN if cnt2 == 0) in the cycle the last bank 1 read issues.
  - RD2 → DRAIN in the cycle the last bank 2 read issues.
  - DRAIN → IDLE once the FIFO is empty, there is no read in flight, and the final handshake (if any) has completed. done pulses in that same transition cycle.
  - start is ignored while not in IDLE.
- Reads:
  - re asserts only in RD1/RD2, only while addr < cnt, and only when occupancy + inflight − pop < 2. The design is credit-based and never overflows.
  - addr starts at 0 and increments on each issued read. Both addresses return to 0 on entering IDLE.
  - Exactly one bank's re may be high in any cycle.
- Return path:
  - On the cycle after re, the dout field extract plus bank tag is pushed into a 2-entry FIFO.
  - dout[20:19] are reserved and ignored.
- Output:
  - kp_* are driven from the FIFO head. kp_valid = FIFO not empty.
  - Fields hold stable while kp_valid && !kp_ready.
  - Pop occurs on kp_valid && kp_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full with a simultaneous pop.
- kp_last = 1 on the entry corresponding to the last read of the last non-empty bank. It is tagged at push time.
- Latency: start in cycle 0 → re in cycle 1 → push in cycle 2 → kp_valid in cycle 2 (head is combinationally visible). With kp_ready held high, throughput is one keypoint per cycle.
- Both counts 0: no reads, no kp_valid; done pulses 2 cycles after start.
- busy = state != IDLE.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W, ROW_W, COL_W, MAX_KP
  - field offsets (ROW_LSB = 10, COL_LSB = 0)
  - FSM state encoding
- These constants are shared with the detect/filter writer so both ends agree on packing.
- One sub-module: kp_fifo2 (2-entry synchronous FIFO with same-cycle push/pop, full/empty, occupancy output).

Test Plan:
- cnt1 = 3, cnt2 = 2, ready held 1, SRAM words preloaded → five outputs in consecutive cycles starting cycle 2:
  - bank 0: (row 1, col 5), (2, 6), (3, 7)
  - bank 1: (4, 8), (5, 9) with kp_last on the last
  - done one cycle after the last handshake
- cnt1 = 4, cnt2 = 0, ready toggling 1010… → all four delivered in order with fields stable during stalls, no duplicates, no bank-2 re, and re never issued with 2 entries committed.
- cnt1 = 0, cnt2 = 0, start → no re, no kp_valid; done at cycle 2; busy high for cycles 1–2.
- cnt1 = 2047, cnt2 = 5 → clamped to 2000 bank-1 reads (last addr 1999), then 5 bank-2 reads; 2005 outputs total.
- rst asserted mid-stream after 3 handshakes → all outputs 0 immediately, no done pulse. A new start then replays from addr 0.
- start pulsed while busy → ignored; counts are unchanged and the sequence completes as originally latched.
